demux_bit_scanner: RTL and testbench
====================================

# demux_bit_scanner

Sequential feeder that sits directly upstream of the 1-to-8 demultiplexer. It accepts one 8-bit byte from a producer over a four-phase /dav_–rfd handshake. It then scans the byte bit by bit over 8 consecutive cycles, driving the data bit on `x0` and its index on `b2_b0`, so the downstream demultiplexer delivers bit i on output line i. A `strobe` output qualifies each scanned bit for the consumer behind the demultiplexer.

## Interface
Parameters:
- none; width fixed at 8 bits / 3 select bits to match the 1-to-8 demultiplexer.

Ports:
- `clock`  in  1  single system clock; all state updates on its rising edge.
- `reset_`  in  1  reset, asynchronous, active-low.
- `dav_`  in  1  producer data-valid, active-low.
- `byte_in`  in  8  data byte; sampled only at the accepting edge.
- `rfd`  out  1  ready-for-data, active-high.
- `x0`  out  1  current scanned bit; feeds demultiplexer data input.
- `b2_b0`  out  3  current bit index; feeds demultiplexer select.
- `strobe`  out  1  high while `x0`/`b2_b0` carry a valid scanned bit.

## Operation
- All outputs are registered.
- FSM has three states:
  - WAIT_DAV: `rfd`=1, `strobe`=0, `x0`=0, `b2_b0`=000.
  - SHIFT: `rfd`=0, `strobe`=1, `b2_b0`=count, `x0`=byte_reg[count].
  - WAIT_END: `rfd`=0, `strobe`=0, `x0`=0, `b2_b0`=000.
- WAIT_DAV → SHIFT when `dav_`=0 is sampled. On that edge: `byte_reg`<=`byte_in`, count<=0.
- SHIFT advances count by 1 per cycle, 0..7. Count never wraps inside a transfer; the edge after count=7 leaves SHIFT.
- Leaving SHIFT:
  - if `dav_`=1 is sampled, go to WAIT_DAV (`rfd`<=1);
  - else go to WAIT_END.
- WAIT_END → WAIT_DAV on the first edge that samples `dav_`=1.
- A `dav_` held low never causes a second transfer. Each byte needs `dav_` high-then-low again.
- `dav_` toggling during SHIFT is ignored; only its value at the exit edge matters.
- `byte_in` may change freely after the accepting edge.
- Bits equal to 0 are still scanned, with `strobe`=1 and `x0`=0. Downstream, all demultiplexer outputs stay low for that cycle.

## Timing
- Reset (async, any state including mid-SHIFT):
  - `rfd`=1, `strobe`=0, `x0`=0, `b2_b0`=000, state WAIT_DAV, count=0;
  - a partially scanned byte is discarded.
- Reset deassertion: the first edge with `reset_`=1 may already accept a byte if `dav_`=0.
- Edge E0 accepts the byte. Cycles after E0..E7 show index 0..7, `strobe`=1: exactly 8 strobe cycles.
- Edge E8: `strobe`<=0.
  - `rfd`<=1 at E8 if `dav_`=1 is sampled there;
  - otherwise `rfd` rises at the edge after `dav_` returns high.
- Minimum transfer period is 9 cycles: next accept at E9 at the earliest, which needs `dav_`=1 sampled at E8 and `dav_`=0 at E9.
- Latency from accepting edge to bit i appearing on `b2_b0`/`x0`: i+1 edges, i.e. bit i is visible after edge E_i.

## Structure
- Shared include file holds:
  - state encoding constants: WAIT_DAV=2'b00, SHIFT=2'b01, WAIT_END=2'b10;
  - byte width (8) and index width (3).
- Unused encoding 2'b11 → treated as WAIT_DAV on the next edge, with reset-value outputs.
- Natural sub-module: `counter_mod8`, a 3-bit counter with synchronous clear and enable, plus async active-low reset.
- The demultiplexer itself is not instantiated here; the integration level wires `x0`/`b2_b0` to it.

## Test plan
- Reset asserted mid-SHIFT (count=3), `byte_in`=8'hA5 → immediately `rfd`=1, `strobe`=0, `x0`=0, `b2_b0`=000. After release, no residual strobes.
- `byte_in`=8'hA5, `dav_` pulsed low 1 cycle → 8 strobe cycles with `b2_b0`=0..7 and `x0`=1,0,1,0,0,1,0,1. `rfd`=1 at E8.
- `byte_in`=8'hFF with `dav_` held low 20 cycles → single 8-cycle scan, then WAIT_END with `rfd`=0. `rfd` rises one edge after `dav_` goes high.
- Back-to-back bytes 8'h01 then 8'h80, `dav_` low again at E9 → second scan starts at E9. `x0`=1 only at index 0 in the first scan and only at index 7 in the second.
- `byte_in` changed to 8'h00 one cycle after accept of 8'h3C → scanned bits still 0,0,1,1,1,1,0,0.
- `dav_` toggled high/low during SHIFT → no restart, no extra strobe, count monotonic 0..7.

Source files
------------

// File: rtl/demux_bit_scanner_pkg.sv
// Shared encodings and widths for the demux bit scanner.
// The state encoding matches the values the integration level expects.
package demux_bit_scanner_pkg;

  localparam int unsigned ByteW = 8;
  localparam int unsigned IdxW  = 3;

  localparam logic [IdxW-1:0] LastIdx = IdxW'(ByteW - 1);

  typedef enum logic [1:0] {
    WaitDav = 2'b00,
    Shift   = 2'b01,
    WaitEnd = 2'b10
  } state_e;

endpackage

// File: rtl/demux_bit_scanner_counter_mod8.sv
// 3-bit counter with synchronous clear (priority over enable) and async active-low reset.
// The next-count value is exported so the owner can register outputs from it.
module counter_mod8
  import demux_bit_scanner_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clr_i,
  input  logic            en_i,
  output logic [IdxW-1:0] cnt_o,
  output logic [IdxW-1:0] cnt_next_o
);

  logic [IdxW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 3'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o      = cnt_q;
  assign cnt_next_o = cnt_d;

endmodule

// File: rtl/demux_bit_scanner.sv
// Accepts a byte over a /dav_-rfd handshake and scans it bit by bit onto x0/b2_b0
// for a downstream 1-to-8 demultiplexer, qualified by strobe.
module demux_bit_scanner
  import demux_bit_scanner_pkg::*;
(
  input  logic             clock,
  input  logic             reset_,
  input  logic             dav_,
  input  logic [ByteW-1:0] byte_in,
  output logic             rfd,
  output logic             x0,
  output logic [IdxW-1:0]  b2_b0,
  output logic             strobe
);

  state_e           state_q, state_d;
  logic [ByteW-1:0] byte_q, byte_d;
  logic [IdxW-1:0]  cnt, cnt_next;
  logic             cnt_clr, cnt_en;

  logic             rfd_q, rfd_d;
  logic             strobe_q, strobe_d;
  logic             x0_q, x0_d;
  logic [IdxW-1:0]  b2_b0_q, b2_b0_d;

  // Clearing outside SHIFT makes the accepting edge load index 0.
  assign cnt_clr = (state_q != Shift) || (cnt == LastIdx);
  assign cnt_en  = (state_q == Shift);

  counter_mod8 u_counter (
    .clk_i      (clock),
    .rst_ni     (reset_),
    .clr_i      (cnt_clr),
    .en_i       (cnt_en),
    .cnt_o      (cnt),
    .cnt_next_o (cnt_next)
  );

  always_comb begin
    state_d = WaitDav;
    byte_d  = byte_q;
    case (state_q)
      WaitDav: begin
        if (!dav_) begin
          state_d = Shift;
          byte_d  = byte_in;
        end
      end
      Shift: begin
        if (cnt == LastIdx) begin
          state_d = dav_ ? WaitDav : WaitEnd;
        end else begin
          state_d = Shift;
        end
      end
      WaitEnd: begin
        state_d = dav_ ? WaitDav : WaitEnd;
      end
      default: begin
        state_d = WaitDav;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_comb begin
    rfd_d    = (state_d == WaitDav);
    strobe_d = (state_d == Shift);
    b2_b0_d  = '0;
    x0_d     = 1'b0;
    if (strobe_d) begin
      b2_b0_d = cnt_next;
      x0_d    = byte_d[cnt_next];
    end
  end

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state_q  <= WaitDav;
      byte_q   <= '0;
      rfd_q    <= 1'b1;
      strobe_q <= 1'b0;
      x0_q     <= 1'b0;
      b2_b0_q  <= '0;
    end else begin
      state_q  <= state_d;
      byte_q   <= byte_d;
      rfd_q    <= rfd_d;
      strobe_q <= strobe_d;
      x0_q     <= x0_d;
      b2_b0_q  <= b2_b0_d;
    end
  end

  assign rfd    = rfd_q;
  assign strobe = strobe_q;
  assign x0     = x0_q;
  assign b2_b0  = b2_b0_q;

endmodule

// File: tb/tb_demux_bit_scanner.sv
// Directed bench for demux_bit_scanner; outputs checked as {rfd, strobe, b2_b0, x0}.
module tb_demux_bit_scanner;

  logic       clock;
  logic       reset_;
  logic       dav_;
  logic [7:0] byte_in;
  logic       rfd;
  logic       x0;
  logic [2:0] b2_b0;
  logic       strobe;

  int tests  = 0;
  int failed = 0;

  localparam logic [5:0] Idle = 6'b10_000_0;
  localparam logic [5:0] Hold = 6'b00_000_0;

  demux_bit_scanner dut (
    .clock   (clock),
    .reset_  (reset_),
    .dav_    (dav_),
    .byte_in (byte_in),
    .rfd     (rfd),
    .x0      (x0),
    .b2_b0   (b2_b0),
    .strobe  (strobe)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [5:0] exp);
    logic [5:0] obs;
    obs = {rfd, strobe, b2_b0, x0};
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %b required %b", tag, obs, exp);
    end
  endtask

  // Runs 8 edges starting with the accepting edge E0, checking index i after E_i.
  // mode 0: dav_ held low; 1: dav_ released after E0; 2: dav_ toggled, high before E8.
  task automatic scan8(input string tag, input logic [7:0] bits, input int mode,
                       input logic [7:0] upset);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("%s idx%0d", tag, i), {1'b0, 1'b1, 3'(i), bits[i]});
      if (i == 0) byte_in = upset;
      if (mode == 1) dav_ = 1'b1;
      if (mode == 2) dav_ = (i == 7) ? 1'b1 : ((i % 2) == 0);
    end
  endtask

  initial begin
    reset_  = 1'b0;
    dav_    = 1'b0;
    byte_in = 8'hA5;
    tick();
    tick();
    chk("reset state", Idle);

    // First edge after release accepts because dav_ is already low.
    @(negedge clock);
    reset_ = 1'b1;
    scan8("A5", 8'b1010_0101, 1, 8'h5A);
    tick();
    chk("A5 E8 rfd", Idle);
    tick();
    chk("A5 idle", Idle);

    // dav_ held low for 20 edges: exactly one scan, then WAIT_END.
    byte_in = 8'hFF;
    dav_    = 1'b0;
    scan8("FF", 8'hFF, 0, 8'hFF);
    for (int k = 8; k < 20; k++) begin
      tick();
      chk($sformatf("FF hold e%0d", k), Hold);
    end
    dav_ = 1'b1;
    tick();
    chk("FF rfd rise", Idle);
    tick();
    chk("FF idle", Idle);

    // Back-to-back at minimum period: second accept at E9.
    byte_in = 8'h01;
    dav_    = 1'b0;
    scan8("B2B 01", 8'h01, 1, 8'h01);
    tick();
    chk("B2B E8", Idle);
    byte_in = 8'h80;
    dav_    = 1'b0;
    scan8("B2B 80", 8'h80, 1, 8'h80);
    tick();
    chk("B2B end", Idle);

    // byte_in changes after accept; latched byte is scanned.
    byte_in = 8'h3C;
    dav_    = 1'b0;
    scan8("3C", 8'b0011_1100, 1, 8'h00);
    tick();
    chk("3C end", Idle);

    // dav_ toggling during SHIFT is ignored.
    byte_in = 8'h96;
    dav_    = 1'b0;
    scan8("toggle", 8'b1001_0110, 2, 8'h69);
    tick();
    chk("toggle end", Idle);
    tick();
    chk("toggle idle", Idle);

    // Async reset mid-SHIFT at count 3.
    byte_in = 8'hA5;
    dav_    = 1'b0;
    tick();
    dav_ = 1'b1;
    tick();
    tick();
    tick();
    chk("pre-reset idx3", 6'b01_011_0);
    #2;
    reset_ = 1'b0;
    #1;
    chk("async reset", Idle);
    tick();
    chk("in reset", Idle);
    @(negedge clock);
    reset_ = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk($sformatf("post-reset e%0d", k), Idle);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
